kbd_scan_ctrl: RTL and testbench

Sequencing controller between the PS/2 byte receiver and the UIBI keyboard slave. It pops raw scan-code bytes from the receiver FIFO and folds the E0 (extended), F0 (break) and E1 (pause) prefixes into single key events. Events are queued in a small event FIFO that the bus side drains. It applies back-pressure to the receiver, so no byte is ever lost downstream of it.

---
 rtl/kbd_pkg.sv | 55 +++++
 rtl/kbd_event_fifo.sv | 71 +++++++
 rtl/kbd_scan_ctrl.sv | 115 +++++++++++
 tb/tb_kbd_scan_ctrl.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/kbd_pkg.sv
// rtl/kbd_pkg.sv - scan-code constants, event layout and decode helpers
package kbd_pkg;

    localparam logic [7:0] SC_EXT   = 8'hE0;
    localparam logic [7:0] SC_BRK   = 8'hF0;
    localparam logic [7:0] SC_PAUSE = 8'hE1;
    localparam logic [7:0] SC_ERR0  = 8'h00;
    localparam logic [7:0] SC_ERR1  = 8'hFF;

    localparam int EVT_W         = 16;
    localparam int EVT_CODE_LSB  = 0;
    localparam int EVT_CODE_W    = 8;
    localparam int EVT_EXT_BIT   = 8;
    localparam int EVT_BRK_BIT   = 9;
    localparam int EVT_PAUSE_BIT = 10;

    typedef struct packed {
        logic [4:0] rsvd;
        logic       pause;
        logic       brk;
        logic       ext;
        logic [7:0] code;
    } kbd_evt_t;

    typedef enum logic [2:0] {
        DEC_SKIP,
        DEC_PAUSE,
        DEC_EXT,
        DEC_BRK,
        DEC_ERR,
        DEC_KEY
    } kbd_dec_e;

    // An active pause skip swallows every byte, including prefixes and error bytes
    function automatic kbd_dec_e classify(input logic skipping, input logic [7:0] b);
        if (skipping)                         return DEC_SKIP;
        else if (b == SC_PAUSE)               return DEC_PAUSE;
        else if (b == SC_EXT)                 return DEC_EXT;
        else if (b == SC_BRK)                 return DEC_BRK;
        else if (b == SC_ERR0 || b == SC_ERR1) return DEC_ERR;
        else                                  return DEC_KEY;
    endfunction

    function automatic kbd_evt_t make_evt(input logic pause, input logic brk,
                                          input logic ext, input logic [7:0] code);
        kbd_evt_t e;
        e.rsvd  = '0;
        e.pause = pause;
        e.brk   = brk;
        e.ext   = ext;
        e.code  = code;
        return e;
    endfunction

endpackage

// File: rtl/kbd_event_fifo.sv
// rtl/kbd_event_fifo.sv - event queue drained by the bus side
module kbd_event_fifo #(
    parameter int DEPTH = 8,
    parameter int W     = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push_i,
    input  logic [W-1:0]             push_data_i,
    input  logic                     pop_i,
    input  logic                     flush_i,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   count_o,
    output logic [W-1:0]             head_o
);
    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  mem_q [DEPTH];
    logic [AW-1:0] wptr_q, wptr_d;
    logic [AW-1:0] rptr_q, rptr_d;
    logic [AW:0]   count_q, count_d;
    logic          do_push, do_pop;

    assign full_o  = (count_q == (AW+1)'(DEPTH));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign head_o  = mem_q[rptr_q];

    assign do_push = push_i & ~full_o & ~flush_i;
    assign do_pop  = pop_i & ~empty_o & ~flush_i;

    // Next pointers and occupancy; flush overrides any push or pop
    always_comb begin
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        count_d = count_q;
        if (flush_i) begin
            wptr_d  = '0;
            rptr_d  = '0;
            count_d = '0;
        end else begin
            if (do_push) wptr_d = wptr_q + 1'b1;
            if (do_pop)  rptr_d = rptr_q + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count_d = count_q + 1'b1;
                2'b01:   count_d = count_q - 1'b1;
                default: count_d = count_q;
            endcase
        end
    end

    // Pointer and occupancy registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
        end
    end

    // Storage needs no reset; the pointers decide what is visible
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wptr_q] <= push_data_i;
    end

endmodule

// File: rtl/kbd_scan_ctrl.sv
// rtl/kbd_scan_ctrl.sv - folds PS/2 prefix bytes into key events
module kbd_scan_ctrl
    import kbd_pkg::*;
#(
    parameter int DEPTH     = 8,
    parameter int PAUSE_LEN = 7
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     rx_ready,
    input  logic [7:0]               rx_data,
    output logic                     rx_pop,
    output logic                     evt_valid,
    output logic [15:0]              evt_data,
    input  logic                     evt_pop,
    output logic [$clog2(DEPTH):0]   evt_count,
    input  logic                     flush,
    output logic                     err,
    input  logic                     err_clr
);
    localparam int SKIP_W = $clog2(PAUSE_LEN + 1);

    logic              ext_q, ext_d;
    logic              brk_q, brk_d;
    logic              err_q, err_d;
    logic              cool_q, cool_d;
    logic [SKIP_W-1:0] skip_q, skip_d;
    logic              accept, push, full, empty;
    kbd_evt_t          push_evt;
    kbd_dec_e          dec;

    // Cooldown gives the receiver a cycle to advance its read pointer and ready flag
    assign accept = rx_ready & ~cool_q & ~full & ~flush & ~rst;
    assign rx_pop = accept;
    assign dec    = classify(skip_q != '0, rx_data);
    assign err    = err_q;

    // Decode of the accepted byte into prefix updates and an optional event push
    always_comb begin
        ext_d    = ext_q;
        brk_d    = brk_q;
        skip_d   = skip_q;
        err_d    = err_q & ~err_clr;
        cool_d   = accept;
        push     = 1'b0;
        push_evt = make_evt(1'b0, 1'b0, 1'b0, 8'h00);
        if (flush) begin
            ext_d  = 1'b0;
            brk_d  = 1'b0;
            skip_d = '0;
            cool_d = 1'b0;
        end else if (accept) begin
            case (dec)
                DEC_SKIP: begin
                    skip_d = skip_q - 1'b1;
                    if (skip_q == SKIP_W'(1)) begin
                        push     = 1'b1;
                        push_evt = make_evt(1'b1, 1'b0, 1'b0, SC_PAUSE);
                    end
                end
                DEC_PAUSE: begin
                    skip_d = SKIP_W'(PAUSE_LEN);
                    ext_d  = 1'b0;
                    brk_d  = 1'b0;
                end
                DEC_EXT: ext_d = 1'b1;
                DEC_BRK: brk_d = 1'b1;
                DEC_ERR: begin
                    err_d = 1'b1;
                    ext_d = 1'b0;
                    brk_d = 1'b0;
                end
                default: begin
                    push     = 1'b1;
                    push_evt = make_evt(1'b0, brk_q, ext_q, rx_data);
                    ext_d    = 1'b0;
                    brk_d    = 1'b0;
                end
            endcase
        end
    end

    // Prefix, skip, cooldown and error state
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ext_q  <= 1'b0;
            brk_q  <= 1'b0;
            err_q  <= 1'b0;
            cool_q <= 1'b0;
            skip_q <= '0;
        end else begin
            ext_q  <= ext_d;
            brk_q  <= brk_d;
            err_q  <= err_d;
            cool_q <= cool_d;
            skip_q <= skip_d;
        end
    end

    kbd_event_fifo #(.DEPTH(DEPTH), .W(EVT_W)) u_fifo (
        .clk         (clk),
        .rst         (rst),
        .push_i      (push),
        .push_data_i (push_evt),
        .pop_i       (evt_pop),
        .flush_i     (flush),
        .full_o      (full),
        .empty_o     (empty),
        .count_o     (evt_count),
        .head_o      (evt_data)
    );

    assign evt_valid = ~empty;

endmodule

// File: tb/tb_kbd_scan_ctrl.sv
// tb/tb_kbd_scan_ctrl.sv - scoreboard bench for kbd_scan_ctrl
module tb_kbd_scan_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        rx_ready = 1'b0;
    logic [7:0]  rx_data = 8'h00;
    logic        rx_pop;
    logic        evt_valid;
    logic [15:0] evt_data;
    logic        evt_pop = 1'b0;
    logic [3:0]  evt_count;
    logic        flush = 1'b0;
    logic        err;
    logic        err_clr = 1'b0;

    logic [7:0]  rxq [$];
    logic [15:0] expq [$];
    int n_pass = 0;
    int n_total = 0;
    int pop_cnt = 0;
    int b2b_viol = 0;
    logic prev_pop = 1'b0;

    kbd_scan_ctrl #(.DEPTH(8), .PAUSE_LEN(7)) dut (
        .clk       (clk),
        .rst       (rst),
        .rx_ready  (rx_ready),
        .rx_data   (rx_data),
        .rx_pop    (rx_pop),
        .evt_valid (evt_valid),
        .evt_data  (evt_data),
        .evt_pop   (evt_pop),
        .evt_count (evt_count),
        .flush     (flush),
        .err       (err),
        .err_clr   (err_clr)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] b);
        rxq.push_back(b);
    endtask

    // Receiver model: pops on rx_pop, then presents the new head
    always @(posedge clk) begin
        if (rx_pop) void'(rxq.pop_front());
        #2;
        rx_ready = (rxq.size() != 0);
        rx_data  = (rxq.size() != 0) ? rxq[0] : 8'h00;
    end

    // Monitor: pop-strobe spacing and scoreboard comparison of consumed events
    always @(negedge clk) begin
        if (rst) begin
            prev_pop = 1'b0;
        end else begin
            if (rx_pop && prev_pop) b2b_viol++;
            prev_pop = rx_pop;
            if (rx_pop) pop_cnt++;
            if (evt_pop && evt_valid) begin
                if (expq.size() == 0) begin
                    n_total++;
                    $display("FAIL evt_unexpected: got %0h expected none", evt_data);
                end else begin
                    chk("evt_data", {16'h0, evt_data}, {16'h0, expq.pop_front()});
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state with a byte already waiting in the receiver
        send(8'h1C);
        expq.push_back(16'h001C);
        cyc(2);
        @(negedge clk);
        chk("rst_rx_pop", rx_pop, 0);
        chk("rst_evt_valid", evt_valid, 0);
        chk("rst_evt_count", evt_count, 0);
        chk("rst_err", err, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        // Single make code and its latency
        @(negedge clk);
        chk("t1_rx_pop", rx_pop, 1);
        @(negedge clk);
        chk("t1_evt_valid", evt_valid, 1);
        chk("t1_head", evt_data, 16'h001C);
        chk("t1_rx_pop_low", rx_pop, 0);
        @(posedge clk); #1;
        evt_pop = 1'b1;
        cyc(1);
        evt_pop = 1'b0;
        @(negedge clk);
        chk("t1_valid_after_pop", evt_valid, 0);
        chk("t1_count_after_pop", evt_count, 0);
        chk("t1_pop_cnt", pop_cnt, 1);
        @(posedge clk); #1;

        // Extended break: E0 F0 75
        evt_pop = 1'b1;
        send(8'hE0); send(8'hF0); send(8'h75);
        expq.push_back(16'h0375);
        cyc(12);
        chk("t2_drained", expq.size(), 0);

        // Pause sequence then a normal key
        send(8'hE1); send(8'h14); send(8'h77); send(8'hE1);
        send(8'hF0); send(8'h14); send(8'hF0); send(8'h77);
        send(8'h1C);
        expq.push_back(16'h04E1);
        expq.push_back(16'h001C);
        cyc(30);
        chk("t3_drained", expq.size(), 0);

        // Fill the FIFO: nine make codes, no draining
        evt_pop = 1'b0;
        for (int i = 0; i < 9; i++) begin
            send(8'h15 + 8'(i));
            expq.push_back(16'h0015 + 16'(i));
        end
        cyc(30);
        @(negedge clk);
        chk("t4_count_full", evt_count, 8);
        chk("t4_rx_pop_blocked", rx_pop, 0);
        chk("t4_ninth_waiting", rxq.size(), 1);
        @(posedge clk); #1;
        evt_pop = 1'b1;
        cyc(1);
        evt_pop = 1'b0;
        cyc(4);
        chk("t4_count_refill", evt_count, 8);
        chk("t4_ninth_taken", rxq.size(), 0);
        evt_pop = 1'b1;
        cyc(12);
        chk("t4_drained", expq.size(), 0);
        chk("t4_count_empty", evt_count, 0);

        // Asynchronous reset mid-sequence discards a pending E0
        evt_pop = 1'b0;
        send(8'h33); send(8'hE0);
        cyc(6);
        chk("t5_count_pre", evt_count, 1);
        @(negedge clk); #2;
        rst = 1'b1;
        #1;
        chk("t5_async_count", evt_count, 0);
        chk("t5_async_valid", evt_valid, 0);
        chk("t5_async_rx_pop", rx_pop, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        evt_pop = 1'b1;
        send(8'h1C);
        expq.push_back(16'h001C);
        cyc(8);
        chk("t5_drained", expq.size(), 0);

        // Error byte after F0, recovery, err_clr and flush
        send(8'hF0); send(8'h00);
        cyc(8);
        chk("t6_err_set", err, 1);
        send(8'h1C);
        expq.push_back(16'h001C);
        cyc(6);
        chk("t6_drained", expq.size(), 0);
        chk("t6_err_sticky", err, 1);
        err_clr = 1'b1;
        cyc(1);
        err_clr = 1'b0;
        chk("t6_err_clr", err, 0);
        evt_pop = 1'b0;
        send(8'h21); send(8'h22); send(8'h23);
        cyc(10);
        chk("t6_count3", evt_count, 3);
        flush = 1'b1;
        cyc(1);
        flush = 1'b0;
        @(negedge clk);
        chk("t6_flush_count", evt_count, 0);
        chk("t6_flush_valid", evt_valid, 0);

        chk("no_b2b_rx_pop", b2b_viol, 0);
        chk("scoreboard_empty", expq.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
